// File: rtl/ser_rx_ctrl_if.sv
// Signal bundle between the receive sequencer and its surroundings:
// serial line and enable in, shift-register control out, byte result out.
`timescale 1ns/1ps
interface ser_rx_ctrl_if;
    logic       en;
    logic       serial_in;
    logic [7:0] par_in;
    logic       shift_en;
    logic       shift_clear;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    // Environment side: line, enable and shift-register contents in.
    modport master (
        output en, serial_in, par_in,
        input  shift_en, shift_clear, data_out, data_valid, frame_err, busy
    );

    // Sequencer side.
    modport slave (
        input  en, serial_in, par_in,
        output shift_en, shift_clear, data_out, data_valid, frame_err, busy
    );
endinterface

// File: rtl/ser_rx_ctrl.sv
// Frame sequencer for an external 8-bit serial-to-parallel shift register.
// Finds the start bit, times bit-centre shifts with a baud counter, checks
// the stop bit and holds the last good byte.
`timescale 1ns/1ps
module ser_rx_ctrl #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic         MHz10,
    input  logic         rst,
    ser_rx_ctrl_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             sync1_q, sync1_d;
    logic             rx_q, rx_d;
    logic             shift_en_q, shift_en_d;
    logic             shift_clear_q, shift_clear_d;
    logic             data_valid_q, data_valid_d;
    logic             frame_err_q, frame_err_d;
    logic [7:0]       data_out_q, data_out_d;

    // Next-state, counters, synchroniser and registered pulse outputs.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_d         = bit_q;
        sync1_d       = bus.serial_in;
        rx_d          = sync1_q;
        shift_en_d    = 1'b0;
        shift_clear_d = 1'b0;
        data_valid_d  = 1'b0;
        frame_err_d   = 1'b0;
        data_out_d    = data_out_q;

        if (!bus.en && state_q != IDLE) begin
            // Abort: drop the frame silently, keep the held byte.
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.en && !rx_q) begin
                        state_d       = START;
                        cnt_d         = '0;
                        shift_clear_d = 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d   = '0;
                        bit_d   = '0;
                        // Still low at mid-bit means a real start bit.
                        state_d = rx_q ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_LAST) begin
                        shift_en_d = 1'b1;
                        cnt_d      = '0;
                        bit_d      = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = STOP;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (rx_q) begin
                            data_out_d   = bus.par_in;
                            data_valid_d = 1'b1;
                            state_d      = IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = BRK;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                BRK: begin
                    // Hold off until the line idles so a stuck-low line
                    // cannot look like a stream of start bits.
                    if (rx_q) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and output registers; synchroniser resets to line-idle.
    always_ff @(posedge MHz10) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_q         <= '0;
            sync1_q       <= 1'b1;
            rx_q          <= 1'b1;
            shift_en_q    <= 1'b0;
            shift_clear_q <= 1'b0;
            data_valid_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            data_out_q    <= 8'h00;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_q         <= bit_d;
            sync1_q       <= sync1_d;
            rx_q          <= rx_d;
            shift_en_q    <= shift_en_d;
            shift_clear_q <= shift_clear_d;
            data_valid_q  <= data_valid_d;
            frame_err_q   <= frame_err_d;
            data_out_q    <= data_out_d;
        end
    end

    assign bus.shift_en    = shift_en_q;
    assign bus.shift_clear = shift_clear_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.frame_err   = frame_err_q;
    assign bus.data_out    = data_out_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
